pipelined_adder_subtractor: RTL

//  Parametrised, pipelined two's-complement adder/subtractor; next generation of the 16-bit ripple unit.

---
 rtl/pipelined_adder_subtractor.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/pipelined_adder_subtractor.sv
// pipelined_adder_subtractor
//   Pipelined two's-complement adder/subtractor with valid/ready streaming.
//   The carry chain is cut into SEGS equal segments, one per pipeline stage,
//   so a new operation can enter every cycle and its result appears SEGS
//   cycles later. Produces carry/borrow, signed overflow, zero and negative
//   flags, plus a sticky overflow indicator.
//   Optional feature macro: ADDSUB_SAT_EN -- when defined, results that
//   overflow are clamped to the most positive / most negative value.
module pipelined_adder_subtractor #(
    parameter int WIDTH = 16,
    parameter int SEGS  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s,
    output logic             out_c,
    output logic             out_v,
    output logic             out_z,
    output logic             out_n,
    output logic             ovf_sticky
);

    // Bits handled by each segment of the carry chain.
    localparam int SW = WIDTH / SEGS;

    if (WIDTH < 2 || SEGS < 1 || (WIDTH % SEGS) != 0) begin : g_param_check
        $error("pipelined_adder_subtractor: WIDTH must be >= 2 and a multiple of SEGS");
    end

    // The whole pipe moves as one: it advances whenever the output slot is
    // empty or being drained, otherwise everything (bubbles included) holds.
    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

`ifdef ADDSUB_SAT_EN
    // Clamp an overflowed result. A set sign bit on overflow means the true
    // result was too large (positive overflow), a clear one means too small.
    function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] raw,
                                                  input logic             ovf);
        logic [WIDTH-1:0] lim;
        lim = raw;
        if (ovf) begin
            if (raw[WIDTH-1]) begin
                lim            = '1;
                lim[WIDTH-1]   = 1'b0;
            end else begin
                lim            = '0;
                lim[WIDTH-1]   = 1'b1;
            end
        end
        return lim;
    endfunction
`endif

    for (genvar k = 0; k < SEGS; k++) begin : g_seg
        // Operand bits not yet consumed when entering segment k, and result
        // bits already produced by the earlier segments.
        localparam int REM  = WIDTH - k * SW;
        localparam int DONE = k * SW;

        logic [REM-1:0]       a_src;
        logic [REM-1:0]       b_src;
        logic                 cin_src;
        logic                 op_src;
        logic                 vld_src;
        logic [SW:0]          seg;
        logic [DONE+SW-1:0]   acc;

        if (k == 0) begin : g_in
            // Subtraction is A + ~B + 1: invert B and inject the op as carry-in.
            assign a_src   = in_a;
            assign b_src   = in_b ^ {WIDTH{in_op}};
            assign cin_src = in_op;
            assign op_src  = in_op;
            assign vld_src = in_valid;
            assign acc     = seg[SW-1:0];
        end else begin : g_chain
            assign a_src   = g_seg[k-1].g_reg.a_p;
            assign b_src   = g_seg[k-1].g_reg.b_p;
            assign cin_src = g_seg[k-1].g_reg.c_p;
            assign op_src  = g_seg[k-1].g_reg.op_p;
            assign vld_src = g_seg[k-1].g_reg.vld_p;
            assign acc     = {seg[SW-1:0], g_seg[k-1].g_reg.sum_p};
        end

        // Segment k adds the lowest remaining slice with the carry from k-1.
        assign seg = {1'b0, a_src[SW-1:0]} + {1'b0, b_src[SW-1:0]} + {{SW{1'b0}}, cin_src};

        if (k < SEGS - 1) begin : g_reg
            logic [REM-SW-1:0]  a_p;
            logic [REM-SW-1:0]  b_p;
            logic [DONE+SW-1:0] sum_p;
            logic               c_p;
            logic               op_p;
            logic               vld_p;

            // ---- stage k boundary: partial sum, carry and skewed upper operand slices ----
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_p <= 1'b0;
                    a_p   <= '0;
                    b_p   <= '0;
                    sum_p <= '0;
                    c_p   <= 1'b0;
                    op_p  <= 1'b0;
                end else if (advance) begin
                    vld_p <= vld_src;
                    a_p   <= a_src[REM-1:SW];
                    b_p   <= b_src[REM-1:SW];
                    sum_p <= acc;
                    c_p   <= seg[SW];
                    op_p  <= op_src;
                end
            end
        end else begin : g_out
            logic             c_msb;
            logic             v_raw;
            logic [WIDTH-1:0] s_fin;

            // Carry into the MSB recovered from the MSB sum bit and its operands;
            // overflow is that carry disagreeing with the carry out.
            assign c_msb = acc[WIDTH-1] ^ a_src[SW-1] ^ b_src[SW-1];
            assign v_raw = seg[SW] ^ c_msb;
`ifdef ADDSUB_SAT_EN
            assign s_fin = saturate(acc, v_raw);
`else
            assign s_fin = acc;
`endif

            // ---- final stage boundary: full result and flags ----
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_valid <= 1'b0;
                    out_s     <= '0;
                    out_c     <= 1'b0;
                    out_v     <= 1'b0;
                    out_z     <= 1'b0;
                    out_n     <= 1'b0;
                end else if (advance) begin
                    out_valid <= vld_src;
                    out_s     <= s_fin;
                    out_c     <= seg[SW] ^ op_src;
                    out_v     <= v_raw;
                    out_z     <= ~|s_fin;
                    out_n     <= s_fin[WIDTH-1];
                end
            end
        end
    end

    // Remember any overflow that actually left the unit; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
        end else if (out_valid && out_ready && out_v) begin
            ovf_sticky <= 1'b1;
        end
    end

endmodule
